alpha_bringup_sequencer: RTL and testbench

ALPHA_BRINGUP_SEQUENCER -- requirements
Module: alpha_bringup_sequencer

---
 rtl/alpha_bringup_sequencer_pkg.sv | 26 ++
 rtl/alpha_bringup_sequencer_pickoff_delay_counter.sv | 30 +++
 rtl/alpha_bringup_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alpha_bringup_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alpha_bringup_sequencer_pkg.sv
// Shared definitions for the alpha bring-up sequencer: FSM state encoding,
// step indices and enable/has_occurred bit positions.
package alpha_bringup_sequencer_pkg;

  typedef enum logic [2:0] {
    S_WAIT_DELAY     = 3'd0,
    S_WAIT_DONE      = 3'd1,
    S_ARMED          = 3'd2,
    S_TRIG_WAIT_DONE = 3'd3,
    S_FAULT          = 3'd4
  } seq_state_t;

  // Step index doubles as the enable_mask / has_occurred bit position.
  localparam logic [1:0] STEP_DRESET        = 2'd0;
  localparam logic [1:0] STEP_LEGACY_SERIAL = 2'd1;
  localparam logic [1:0] STEP_I2C           = 2'd2;

  // The trigger has no step index; it only owns bit 3 of the masks.
  localparam int unsigned BIT_TRIGGER = 3;

  // States in which an operation is outstanding and the timeout runs.
  function automatic logic awaits_done(input seq_state_t st);
    return (st == S_WAIT_DONE) || (st == S_TRIG_WAIT_DONE);
  endfunction

endpackage

// File: rtl/alpha_bringup_sequencer_pickoff_delay_counter.sv
// Free-running up-counter that flags expiry when bit PICKOFF sets and then
// holds, so a long wait never wraps back to "not expired".
module pickoff_delay_counter #(
  parameter int PICKOFF = 4
) (
  input  logic clock100,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [PICKOFF:0] COUNT_ONE = {{PICKOFF{1'b0}}, 1'b1};

  logic [PICKOFF:0] count_r;

  // Count while enabled until the pickoff bit sets; clear has priority.
  always_ff @(posedge clock100) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (enable && !count_r[PICKOFF]) begin
      count_r <= count_r + COUNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = count_r[PICKOFF];

endmodule

// File: rtl/alpha_bringup_sequencer.sv
// Bring-up sequencer: walks dreset, legacy serial and i2c steps with a fixed
// inter-step delay and a per-operation timeout, then arms for triggers.
module alpha_bringup_sequencer
  import alpha_bringup_sequencer_pkg::*;
#(
  parameter int DELAY_PICKOFF   = 26,
  parameter int TIMEOUT_PICKOFF = 24
) (
  input  logic       clock100,
  input  logic       reset,
  input  logic [3:0] enable_mask,
  input  logic       trigger_request,
  input  logic       restart,
  input  logic       step_done,
  output logic       initiate_dreset_sequence,
  output logic       initiate_legacy_serial_sequence,
  output logic       initiate_i2c_transfer,
  output logic       initiate_trigger,
  output logic [3:0] has_occurred,
  output logic       busy,
  output logic       ready_for_trigger,
  output logic       timeout_error,
  output logic [2:0] state
);

  seq_state_t state_r;
  logic [1:0] step_r;
  logic       initiate_dreset_r;
  logic       initiate_legacy_r;
  logic       initiate_i2c_r;
  logic       initiate_trigger_r;
  logic [3:0] has_occurred_r;
  logic       busy_r;
  logic       ready_r;
  logic       timeout_error_r;

  logic step_enabled_s;
  logic delay_enable_s;
  logic delay_clear_s;
  logic delay_expired_s;
  logic timeout_enable_s;
  logic timeout_clear_s;
  logic timeout_expired_s;
  logic advance_s;

  // Counter control and the step-advance decision (skip or step_done).
  always_comb begin
    step_enabled_s   = enable_mask[step_r];
    delay_enable_s   = (state_r == S_WAIT_DELAY);
    delay_clear_s    = restart || !delay_enable_s || !step_enabled_s;
    timeout_enable_s = awaits_done(state_r);
    timeout_clear_s  = restart || !timeout_enable_s;
    advance_s        = (delay_enable_s && !step_enabled_s) ||
                       ((state_r == S_WAIT_DONE) && step_done);
  end

  pickoff_delay_counter #(.PICKOFF(DELAY_PICKOFF)) u_delay_counter (
    .clock100 (clock100),
    .reset    (reset),
    .clear    (delay_clear_s),
    .enable   (delay_enable_s),
    .expired  (delay_expired_s)
  );

  pickoff_delay_counter #(.PICKOFF(TIMEOUT_PICKOFF)) u_timeout_counter (
    .clock100 (clock100),
    .reset    (reset),
    .clear    (timeout_clear_s),
    .enable   (timeout_enable_s),
    .expired  (timeout_expired_s)
  );

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock100) begin
    if (reset) begin
      state_r            <= S_WAIT_DELAY;
      step_r             <= STEP_DRESET;
      initiate_dreset_r  <= 1'b0;
      initiate_legacy_r  <= 1'b0;
      initiate_i2c_r     <= 1'b0;
      initiate_trigger_r <= 1'b0;
      has_occurred_r     <= 4'b0000;
      busy_r             <= 1'b0;
      ready_r            <= 1'b0;
      timeout_error_r    <= 1'b0;
    end else begin
      initiate_dreset_r  <= 1'b0;
      initiate_legacy_r  <= 1'b0;
      initiate_i2c_r     <= 1'b0;
      initiate_trigger_r <= 1'b0;
      if (restart) begin
        state_r         <= S_WAIT_DELAY;
        step_r          <= STEP_DRESET;
        has_occurred_r  <= 4'b0000;
        timeout_error_r <= 1'b0;
        busy_r          <= 1'b1;
        ready_r         <= 1'b0;
      end else if (advance_s) begin
        if (step_r == STEP_I2C) begin
          state_r <= S_ARMED;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end else begin
          state_r <= S_WAIT_DELAY;
          step_r  <= step_r + 2'd1;
          busy_r  <= 1'b1;
          ready_r <= 1'b0;
        end
      end else begin
        case (state_r)
          S_WAIT_DELAY: begin
            busy_r <= 1'b1;
            if (delay_expired_s) begin
              has_occurred_r[step_r] <= 1'b1;
              state_r                <= S_WAIT_DONE;
              case (step_r)
                STEP_DRESET:        initiate_dreset_r <= 1'b1;
                STEP_LEGACY_SERIAL: initiate_legacy_r <= 1'b1;
                STEP_I2C:           initiate_i2c_r    <= 1'b1;
                default: begin
                  state_r         <= S_FAULT;
                  busy_r          <= 1'b0;
                  timeout_error_r <= 1'b1;
                end
              endcase
            end
          end
          S_WAIT_DONE: begin
            if (timeout_expired_s) begin
              state_r         <= S_FAULT;
              busy_r          <= 1'b0;
              timeout_error_r <= 1'b1;
            end
          end
          S_ARMED: begin
            if (trigger_request && enable_mask[BIT_TRIGGER]) begin
              initiate_trigger_r          <= 1'b1;
              has_occurred_r[BIT_TRIGGER] <= 1'b1;
              state_r                     <= S_TRIG_WAIT_DONE;
              busy_r                      <= 1'b1;
              ready_r                     <= 1'b0;
            end
          end
          S_TRIG_WAIT_DONE: begin
            if (step_done) begin
              state_r <= S_ARMED;
              busy_r  <= 1'b0;
              ready_r <= 1'b1;
            end else if (timeout_expired_s) begin
              state_r         <= S_FAULT;
              busy_r          <= 1'b0;
              timeout_error_r <= 1'b1;
            end
          end
          S_FAULT: begin
            state_r <= S_FAULT;
          end
          default: begin
            state_r         <= S_FAULT;
            busy_r          <= 1'b0;
            ready_r         <= 1'b0;
            timeout_error_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign initiate_dreset_sequence        = initiate_dreset_r;
  assign initiate_legacy_serial_sequence = initiate_legacy_r;
  assign initiate_i2c_transfer           = initiate_i2c_r;
  assign initiate_trigger                = initiate_trigger_r;
  assign has_occurred                    = has_occurred_r;
  assign busy                            = busy_r;
  assign ready_for_trigger               = ready_r;
  assign timeout_error                   = timeout_error_r;
  assign state                           = state_r;

endmodule

// File: tb/tb_alpha_bringup_sequencer.sv
// Self-checking bench for alpha_bringup_sequencer with short pickoffs.
// Expected pulse edges are derived arithmetically from the step rules.
module tb_alpha_bringup_sequencer;
  import alpha_bringup_sequencer_pkg::*;

  logic       clock100 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] enable_mask = 4'b1111;
  logic       trigger_request = 1'b0;
  logic       restart = 1'b0;
  logic       step_done = 1'b0;
  logic       initiate_dreset_sequence;
  logic       initiate_legacy_serial_sequence;
  logic       initiate_i2c_transfer;
  logic       initiate_trigger;
  logic [3:0] has_occurred;
  logic       busy;
  logic       ready_for_trigger;
  logic       timeout_error;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  alpha_bringup_sequencer #(.DELAY_PICKOFF(4), .TIMEOUT_PICKOFF(6)) dut (
    .clock100                        (clock100),
    .reset                           (reset),
    .enable_mask                     (enable_mask),
    .trigger_request                 (trigger_request),
    .restart                         (restart),
    .step_done                       (step_done),
    .initiate_dreset_sequence        (initiate_dreset_sequence),
    .initiate_legacy_serial_sequence (initiate_legacy_serial_sequence),
    .initiate_i2c_transfer           (initiate_i2c_transfer),
    .initiate_trigger                (initiate_trigger),
    .has_occurred                    (has_occurred),
    .busy                            (busy),
    .ready_for_trigger               (ready_for_trigger),
    .timeout_error                   (timeout_error),
    .state                           (state)
  );

  always #5 clock100 = ~clock100;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample outputs at the next negedge.
  task automatic cyc(input logic sd, input logic tr, input logic rs,
                     input logic [3:0] exp_pulse, input logic [2:0] exp_flags,
                     input logic [3:0] exp_ho, input string tag);
    step_done = sd;
    trigger_request = tr;
    restart = rs;
    @(posedge clock100);
    @(negedge clock100);
    step_done = 1'b0;
    trigger_request = 1'b0;
    restart = 1'b0;
    chk({tag, "_pulse"}, {4'b0000, initiate_trigger, initiate_i2c_transfer,
        initiate_legacy_serial_sequence, initiate_dreset_sequence}, {4'b0000, exp_pulse});
    chk({tag, "_flags"}, {5'b00000, timeout_error, ready_for_trigger, busy}, {5'b00000, exp_flags});
    chk({tag, "_occ"}, {4'b0000, has_occurred}, {4'b0000, exp_ho});
  endtask

  task automatic do_reset(input int n, input string tag);
    reset = 1'b1;
    repeat (n) @(posedge clock100);
    @(negedge clock100);
    chk({tag, "_pulse"}, {4'b0000, initiate_trigger, initiate_i2c_transfer,
        initiate_legacy_serial_sequence, initiate_dreset_sequence}, 8'h00);
    chk({tag, "_flags"}, {5'b00000, timeout_error, ready_for_trigger, busy}, 8'h00);
    chk({tag, "_occ"}, {4'b0000, has_occurred}, 8'h00);
    chk({tag, "_state"}, {5'b00000, state}, {5'b00000, S_WAIT_DELAY});
    reset = 1'b0;
  endtask

  // Runs the bring-up from a fresh start (edge 0 = reset/restart edge).
  // Each enabled step pulses 17 edges after the previous advance, a skip
  // costs one edge, and step_done returns d edges after the pulse.
  task automatic run_seq(input logic [3:0] mask, input int d0, input int d1, input int d2,
                         input bit withhold, input string tag);
    int pe[3];
    int de[3];
    int dl[3];
    int t;
    int last;
    int armed_from;
    int fault_from;
    logic [3:0] ep;
    logic [3:0] eho;
    logic [2:0] ef;
    logic sd;
    logic tr;
    logic inwin;
    enable_mask = mask;
    dl[0] = d0;
    dl[1] = d1;
    dl[2] = d2;
    t = 0;
    for (int s = 0; s < 3; s++) begin
      if (mask[s]) begin
        t = t + 17;
        pe[s] = t;
        de[s] = t + dl[s];
        t = de[s];
      end else begin
        t = t + 1;
        pe[s] = 0;
        de[s] = 0;
      end
    end
    if (withhold) begin
      de[2] = 0;
      last = pe[2] + 65;
      armed_from = 1000000;
      fault_from = last;
    end else begin
      last = t + 2;
      armed_from = t;
      fault_from = 1000000;
    end
    for (int e = 1; e <= last; e++) begin
      ep = 4'b0000;
      eho = 4'b0000;
      sd = 1'b0;
      inwin = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (pe[s] != 0 && e == pe[s]) ep[s] = 1'b1;
        if (pe[s] != 0 && e >= pe[s]) eho[s] = 1'b1;
        if (de[s] != 0 && e == de[s]) sd = 1'b1;
        if (pe[s] != 0 && e > pe[s] && (de[s] == 0 || e <= de[s])) inwin = 1'b1;
      end
      if (!inwin && $urandom_range(7) == 0) sd = 1'b1;
      tr = (e <= t || withhold) ? ($urandom_range(3) == 0) : 1'b0;
      ef = {e >= fault_from, e >= armed_from, (e < armed_from) && (e < fault_from)};
      cyc(sd, tr, 1'b0, ep, ef, eho, tag);
      if (e == 1) chk({tag, "_state_e1"}, {5'b00000, state}, {5'b00000, S_WAIT_DELAY});
    end
    chk({tag, "_state_end"}, {5'b00000, state},
        withhold ? {5'b00000, S_FAULT} : {5'b00000, S_ARMED});
  endtask

  initial begin
    logic [3:0] m;

    do_reset(3, "reset");
    run_seq(4'b1111, 3, 3, 3, 1'b0, "all_on");

    cyc(1'b0, 1'b1, 1'b0, 4'b1000, 3'b001, 4'b1111, "trig1");
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 4'b1111, "trig_wait");
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 3'b001, 4'b1111, "trig2_ignored");
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 3'b010, 4'b1111, "trig_done");
    cyc(1'b0, 1'b1, 1'b0, 4'b1000, 3'b001, 4'b1111, "trig3");
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 3'b010, 4'b1111, "trig3_done");

    enable_mask = 4'b0111;
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 3'b010, 4'b1111, "trig_masked");
    enable_mask = 4'b1111;

    cyc(1'b0, 1'b1, 1'b1, 4'b0000, 3'b001, 4'b0000, "restart_trig");
    chk("restart_trig_state", {5'b00000, state}, {5'b00000, S_WAIT_DELAY});
    run_seq(4'b1101, 3, 5, int'($urandom_range(40, 1)), 1'b0, "skip_legacy");

    for (int i = 0; i < 4; i++) begin
      m = 4'($urandom_range(15));
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 3'b001, 4'b0000, "restart");
      run_seq(m, int'($urandom_range(40, 1)), int'($urandom_range(40, 1)),
              int'($urandom_range(40, 1)), 1'b0, "rand");
      cyc(1'b0, 1'b1, 1'b0, {m[3], 3'b000}, m[3] ? 3'b001 : 3'b010, m, "rand_trig");
      cyc(1'b1, 1'b0, 1'b0, 4'b0000, 3'b010, m, "rand_trig_done");
    end

    cyc(1'b0, 1'b0, 1'b1, 4'b0000, 3'b001, 4'b0000, "restart_to");
    run_seq(4'b1111, int'($urandom_range(40, 1)), int'($urandom_range(40, 1)), 1, 1'b1, "timeout");
    repeat (4) cyc(1'($urandom_range(1)), 1'b1, 1'b0, 4'b0000, 3'b100, 4'b0111, "fault_hold");
    cyc(1'b0, 1'b0, 1'b1, 4'b0000, 3'b001, 4'b0000, "fault_restart");
    run_seq(4'b1111, 3, 3, 3, 1'b0, "after_fault");

    cyc(1'b0, 1'b0, 1'b1, 4'b0000, 3'b001, 4'b0000, "restart_pre_reset");
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 4'b0000, "delay_count");
    do_reset(1, "reset_mid_delay");
    run_seq(4'b1111, 2, 4, 6, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
